// File: rtl/ts_pkg.sv
// Shared definitions for the TS packet aligner: lock FSM encoding, MPEG-TS sync byte
// and the default packet length.
package ts_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } ts_state_e;

  localparam logic [7:0] TS_SYNC_BYTE   = 8'h47;
  localparam int         TS_PKT_LEN_DEF = 188;

endpackage

// File: rtl/ts_packet_aligner.sv
// TS packet aligner: finds 0x47 headers one packet apart, locks, and forwards framed bytes.
// Optional `define TS_PKT_STATS_EN adds saturating pkt_cnt / loss_cnt outputs.
//
// state  | meaning
// HUNT   | every accepted byte is checked for the sync byte
// VERIFY | candidate found, headers checked only at packet boundaries
// LOCK   | aligned; bytes forwarded with sop/eop, bad headers counted
module ts_packet_aligner
  import ts_pkg::*;
#(
  parameter int PKT_LEN    = TS_PKT_LEN_DEF,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 3
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic [9:0]  fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_r_en,
  output logic [7:0]  ts_data,
  output logic        ts_valid,
  output logic        ts_sop,
  output logic        ts_eop,
  output logic        locked,
  output logic        sync_err
`ifdef TS_PKT_STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [15:0] loss_cnt
`endif
);

  localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);

  ts_state_e     state_q;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;
  logic          rd_q;
  logic [7:0]    ts_data_q;
  logic          ts_valid_q, ts_sop_q, ts_eop_q, locked_q, sync_err_q;
  logic          accept, cand, at_hdr;
  logic          unused_sync_flag;
`ifdef TS_PKT_STATS_EN
  logic [15:0]   pkt_cnt_q, loss_cnt_q;
`endif

  assign fifo_r_en = !fifo_empty && !rst;

  // FIFO data lags the read by one cycle; only words flagged valid count as bytes
  assign accept = rd_q && fifo_data[1];
  assign cand   = (fifo_data[9:2] == TS_SYNC_BYTE);
  assign at_hdr = (byte_cnt_q == '0);

  assign byte_cnt_d = (byte_cnt_q == LAST) ? '0 : byte_cnt_q + 1'b1;
  assign good_d     = good_q + 1'b1;
  assign bad_d      = bad_q + 1'b1;

  assign unused_sync_flag = fifo_data[0];

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q    <= ST_HUNT;
      byte_cnt_q <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      rd_q       <= 1'b0;
      ts_data_q  <= '0;
      ts_valid_q <= 1'b0;
      ts_sop_q   <= 1'b0;
      ts_eop_q   <= 1'b0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
`ifdef TS_PKT_STATS_EN
      pkt_cnt_q  <= '0;
      loss_cnt_q <= '0;
`endif
    end else begin
      rd_q       <= fifo_r_en;
      ts_valid_q <= 1'b0;
      ts_sop_q   <= 1'b0;
      ts_eop_q   <= 1'b0;
      sync_err_q <= 1'b0;
      if (accept) begin
        case (state_q)
          ST_HUNT: begin
            if (cand) begin
              byte_cnt_q <= byte_cnt_d;
              good_q     <= GW'(1);
              if (LOCK_CNT == 1) begin
                state_q  <= ST_LOCK;
                locked_q <= 1'b1;
                bad_q    <= '0;
              end else begin
                state_q  <= ST_VERIFY;
              end
            end
          end
          ST_VERIFY: begin
            byte_cnt_q <= byte_cnt_d;
            if (at_hdr) begin
              if (!cand) begin
                state_q    <= ST_HUNT;
                byte_cnt_q <= '0;
                good_q     <= '0;
              end else begin
                good_q <= good_d;
                if (good_d == GW'(LOCK_CNT)) begin
                  state_q  <= ST_LOCK;
                  locked_q <= 1'b1;
                  bad_q    <= '0;
                end
              end
            end
          end
          ST_LOCK: begin
            byte_cnt_q <= byte_cnt_d;
            ts_data_q  <= fifo_data[9:2];
            ts_valid_q <= 1'b1;
            ts_sop_q   <= at_hdr;
            ts_eop_q   <= (byte_cnt_q == LAST);
            sync_err_q <= at_hdr && !cand;
`ifdef TS_PKT_STATS_EN
            if (byte_cnt_q == LAST && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
`endif
            if (at_hdr) begin
              if (cand) begin
                bad_q <= '0;
              end else if (bad_d == BW'(UNLOCK_CNT)) begin
                // the failing header itself was still forwarded above
                state_q    <= ST_HUNT;
                locked_q   <= 1'b0;
                byte_cnt_q <= '0;
                good_q     <= '0;
                bad_q      <= '0;
`ifdef TS_PKT_STATS_EN
                if (loss_cnt_q != 16'hFFFF) loss_cnt_q <= loss_cnt_q + 16'd1;
`endif
              end else begin
                bad_q <= bad_d;
              end
            end
          end
          default: begin
            state_q  <= ST_HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ts_data  = ts_data_q;
  assign ts_valid = ts_valid_q;
  assign ts_sop   = ts_sop_q;
  assign ts_eop   = ts_eop_q;
  assign locked   = locked_q;
  assign sync_err = sync_err_q;
`ifdef TS_PKT_STATS_EN
  assign pkt_cnt  = pkt_cnt_q;
  assign loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_ts_packet_aligner.sv
// Self-checking bench for ts_packet_aligner: randomized FIFO traffic against a
// byte-stream reference model; build with +define+TS_PKT_STATS_EN to also check the stats.
module tb_ts_packet_aligner;

  localparam int PKT_LEN    = 188;
  localparam int LOCK_CNT   = 3;
  localparam int UNLOCK_CNT = 3;

  logic       clk1 = 1'b0;
  logic       rst;
  logic [9:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_r_en;
  logic [7:0] ts_data;
  logic       ts_valid, ts_sop, ts_eop, locked, sync_err;
`ifdef TS_PKT_STATS_EN
  logic [15:0] pkt_cnt, loss_cnt;
`endif

  ts_packet_aligner #(
    .PKT_LEN   (PKT_LEN),
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT)
  ) dut (
    .clk1      (clk1),
    .rst       (rst),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_r_en (fifo_r_en),
    .ts_data   (ts_data),
    .ts_valid  (ts_valid),
    .ts_sop    (ts_sop),
    .ts_eop    (ts_eop),
    .locked    (locked),
    .sync_err  (sync_err)
`ifdef TS_PKT_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt),
    .loss_cnt  (loss_cnt)
`endif
  );

  always #5 clk1 = ~clk1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: works on the stream of accepted bytes, framing by the
  // distance from the anchoring header rather than a wrapped counter.
  int   m_idx = 0, m_anchor = 0, m_good = 0, m_bad = 0;
  bit   m_sync = 0, m_lock = 0;
  bit   exp_valid = 0, exp_sop = 0, exp_eop = 0, exp_err = 0;
  logic [7:0] exp_data = '0;
  int   exp_pkt = 0, exp_loss = 0;

  function automatic void model_reset();
    m_sync = 0; m_lock = 0; m_good = 0; m_bad = 0;
    exp_valid = 0; exp_sop = 0; exp_eop = 0; exp_err = 0; exp_data = '0;
    exp_pkt = 0; exp_loss = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int pos;
    bit c;
    c = (b == 8'h47);
    exp_valid = 0; exp_sop = 0; exp_eop = 0; exp_err = 0;
    if (!m_sync) begin
      if (c) begin
        m_sync = 1; m_anchor = m_idx; m_good = 1; m_bad = 0;
        m_lock = (LOCK_CNT == 1);
      end
    end else begin
      pos = (m_idx - m_anchor) % PKT_LEN;
      if (m_lock) begin
        exp_valid = 1; exp_data = b;
        exp_sop = (pos == 0);
        exp_eop = (pos == PKT_LEN - 1);
        exp_err = (pos == 0) && !c;
        if (exp_eop && exp_pkt < 65535) exp_pkt++;
        if (pos == 0) begin
          if (c) m_bad = 0;
          else begin
            m_bad++;
            if (m_bad == UNLOCK_CNT) begin
              m_sync = 0; m_lock = 0;
              if (exp_loss < 65535) exp_loss++;
            end
          end
        end
      end else if (pos == 0) begin
        if (c) begin
          m_good++;
          if (m_good == LOCK_CNT) begin m_lock = 1; m_bad = 0; end
        end else begin
          m_sync = 0;
        end
      end
    end
    m_idx++;
  endfunction

  logic [9:0] src_q[$];
  bit pend  = 0;
  bit tog_q = 0;
  int obs_valid = 0, obs_sop = 0, obs_eop = 0, obs_err = 0;
  logic [7:0] last_sop_data = '0;

  function automatic void clr_obs();
    obs_valid = 0; obs_sop = 0; obs_eop = 0; obs_err = 0;
  endfunction

  function automatic void push_pkt(input logic [7:0] hdr, input int stray_at, input int inval_pct);
    for (int i = 0; i < PKT_LEN; i++) begin
      logic [7:0] b;
      if (i == 0) b = hdr;
      else if (i == stray_at) b = 8'h47;
      else begin
        b = 8'($urandom);
        if (b == 8'h47) b = 8'h46;
      end
      while ($urandom_range(0, 99) < inval_pct)
        src_q.push_back({8'($urandom), 1'b0, 1'($urandom)});
      src_q.push_back({b, 1'b1, 1'($urandom)});
    end
  endfunction

  // One clock cycle: inputs driven just after the rising edge, r_en checked on
  // the falling edge, outputs checked 1 time unit after the next rising edge.
  task automatic cycle(input bit do_rst, input int empty_pct, input bit tog);
    logic [9:0] w;
    bit acc;
    rst = do_rst;
    if (pend && src_q.size() > 0) w = src_q.pop_front();
    else begin
      w = 10'($urandom);
      if ($urandom_range(0, 3) == 0) w = {8'h47, 1'b1, 1'($urandom)};
    end
    fifo_data = w;
    tog_q = ~tog_q;
    fifo_empty = (src_q.size() == 0) || (tog ? tog_q : ($urandom_range(0, 99) < empty_pct));
    acc = pend && w[1] && !do_rst;
    @(negedge clk1);
    chk("fifo_r_en", fifo_r_en, !fifo_empty && !do_rst);
    pend = !fifo_empty && !do_rst;
    @(posedge clk1);
    #1;
    if (do_rst) model_reset();
    else if (acc) model_byte(w[9:2]);
    else begin
      exp_valid = 0; exp_sop = 0; exp_eop = 0; exp_err = 0;
    end
    chk("ts_valid", ts_valid, exp_valid);
    chk("ts_sop", ts_sop, exp_sop);
    chk("ts_eop", ts_eop, exp_eop);
    chk("sync_err", sync_err, exp_err);
    chk("locked", locked, m_lock);
    if (exp_valid) chk("ts_data", ts_data, exp_data);
    if (do_rst) chk("rst_ts_data", ts_data, 8'h00);
`ifdef TS_PKT_STATS_EN
    chk("pkt_cnt", pkt_cnt, exp_pkt);
    chk("loss_cnt", loss_cnt, exp_loss);
`endif
    if (ts_valid) obs_valid++;
    if (ts_sop) begin obs_sop++; last_sop_data = ts_data; end
    if (ts_eop) obs_eop++;
    if (sync_err) obs_err++;
  endtask

  task automatic drain(input int empty_pct, input bit tog);
    int budget;
    budget = 20000;
    while ((src_q.size() > 0 || pend) && budget > 0) begin
      cycle(1'b0, empty_pct, tog);
      budget--;
    end
    if (budget == 0) chk("drain_timeout", 1, 0);
    repeat (3) cycle(1'b0, empty_pct, tog);
  endtask

  initial begin
    int budget;
    rst = 1'b1; fifo_empty = 1'b1; fifo_data = '0;
    @(posedge clk1);
    #1;
    repeat (3) cycle(1'b1, 0, 1'b0);
    chk("reset_locked", locked, 0);
    chk("reset_valid", ts_valid, 0);
    repeat (4) cycle(1'b0, 0, 1'b0);

    // three clean headers lock, packet 4 is framed
    clr_obs();
    repeat (4) push_pkt(8'h47, -1, 0);
    drain(20, 1'b0);
    chk("A_locked", locked, 1);
    chk("A_bytes", obs_valid, 375);
    chk("A_sop", obs_sop, 1);
    chk("A_eop", obs_eop, 2);
    chk("A_sop_data", last_sop_data, 8'h47);

    // single bad header while locked
    clr_obs();
    push_pkt(8'h00, -1, 10);
    push_pkt(8'h47, -1, 10);
    drain(30, 1'b0);
    chk("B_err", obs_err, 1);
    chk("B_locked", locked, 1);
    chk("B_bytes", obs_valid, 376);

    // two bad headers after the clear must not yet drop lock
    clr_obs();
    push_pkt(8'h00, -1, 5);
    push_pkt(8'hB8, -1, 5);
    drain(10, 1'b0);
    chk("C1_locked", locked, 1);
    chk("C1_err", obs_err, 2);
    // third bad header drops lock; nothing forwarded after it
    clr_obs();
    push_pkt(8'h12, -1, 5);
    push_pkt(8'h12, -1, 5);
    drain(10, 1'b0);
    chk("C2_locked", locked, 0);
    chk("C2_bytes", obs_valid, 1);
    chk("C2_err", obs_err, 1);
`ifdef TS_PKT_STATS_EN
    chk("C2_loss_cnt", loss_cnt, 1);
`endif

    // stray sync in VERIFY is ignored; mismatched boundary returns to HUNT
    clr_obs();
    push_pkt(8'h47, 50, 0);
    push_pkt(8'h00, -1, 0);
    push_pkt(8'h47, -1, 0);
    push_pkt(8'h47, -1, 0);
    drain(15, 1'b0);
    chk("D_locked", locked, 0);
    chk("D_bytes", obs_valid, 0);
    clr_obs();
    push_pkt(8'h47, -1, 0);
    drain(15, 1'b0);
    chk("D_relock", locked, 1);
    chk("D_relock_bytes", obs_valid, 187);

    // toggling empty plus invalid words must not disturb framing
    clr_obs();
    repeat (3) push_pkt(8'h47, -1, 30);
    drain(0, 1'b1);
    chk("E_bytes", obs_valid, 564);
    chk("E_sop", obs_sop, 3);
    chk("E_eop", obs_eop, 3);
    chk("E_err", obs_err, 0);

    // reset at byte 100 of a locked packet
    clr_obs();
    repeat (2) push_pkt(8'h47, -1, 0);
    budget = 2000;
    while (obs_valid < 101 && budget > 0) begin
      cycle(1'b0, 10, 1'b0);
      budget--;
    end
    if (budget == 0) chk("F_wait_timeout", 1, 0);
    cycle(1'b1, 10, 1'b0);
    chk("F_rst_valid", ts_valid, 0);
    chk("F_rst_locked", locked, 0);
    chk("F_rst_data", ts_data, 8'h00);
    src_q.delete();
    repeat (3) cycle(1'b0, 0, 1'b0);
    clr_obs();
    repeat (4) push_pkt(8'h47, -1, 0);
    drain(20, 1'b0);
    chk("F_relock", locked, 1);
    chk("F_bytes", obs_valid, 375);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
